// File: rtl/pc_circuit_if.sv
// ---------------------------------------------------------------------------
// pc_circuit_if
// Purpose : Groups the next-PC select bus between the decode/control unit and
//           the program-counter block.
// Signals : disp8          8-bit signed conditional-branch displacement (words)
//           JMP            unconditional-jump enable, qualifies the flag_* selects
//           BRANCH         taken-conditional-branch enable
//           flag_Rd_PC     with JMP: target = Rd
//           flag_label_PC  with JMP: target = BASE + label11
//           flag_Rm_PC     with JMP: target = Rm
//           label11        11-bit signed jump displacement (words)
//           Rd, Rm         16-bit register values for absolute jumps
//           Q              current PC (instruction memory address)
// Modports: master = control side (drives selects, reads Q)
//           slave  = PC block (reads selects, drives Q)
// ---------------------------------------------------------------------------
interface pc_circuit_if;
    logic [7:0]  disp8;
    logic        JMP;
    logic        BRANCH;
    logic        flag_Rd_PC;
    logic        flag_label_PC;
    logic        flag_Rm_PC;
    logic [10:0] label11;
    logic [15:0] Rd;
    logic [15:0] Rm;
    logic [15:0] Q;

    modport master (
        output disp8, JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC,
               label11, Rd, Rm,
        input  Q
    );

    modport slave (
        input  disp8, JMP, BRANCH, flag_Rd_PC, flag_label_PC, flag_Rm_PC,
               label11, Rd, Rm,
        output Q
    );
endinterface

// File: rtl/pc_circuit.sv
// ---------------------------------------------------------------------------
// pc_circuit
// Purpose : Program-counter register and next-PC selection for the
//           single-cycle 16-bit RISC core. Q is word-addressed.
// Ports   : clk  rising-edge clock
//           clr  asynchronous active-high reset, loads RESET_VECTOR
//           bus  pc_circuit_if.slave (select inputs in, Q out)
// Params  : RESET_VECTOR  value held in the PC while clr is asserted
// Macro   : PC_REL_NEXT_EN  when defined, PC-relative targets (disp8,
//           label11) are computed from PC+1 instead of PC. Absolute jumps,
//           the sequential increment and reset are the same in both builds.
// ---------------------------------------------------------------------------
module pc_circuit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic          clk,
    input  logic          clr,
    pc_circuit_if.slave   bus
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] seq_pc;
    logic [15:0] rel_base;
    logic [15:0] disp8_ext;
    logic [15:0] label11_ext;

    assign seq_pc      = pc_q + 16'd1;
    assign disp8_ext   = {{8{bus.disp8[7]}}, bus.disp8};
    assign label11_ext = {{5{bus.label11[10]}}, bus.label11};

`ifdef PC_REL_NEXT_EN
    assign rel_base = seq_pc;
`else
    assign rel_base = pc_q;
`endif

    // Jump sources win over BRANCH; a JMP with no flag set falls through to
    // the branch/sequential choice. All arithmetic wraps modulo 2^16.
    always_comb begin
        pc_d = seq_pc;
        if (bus.JMP && bus.flag_Rd_PC) begin
            pc_d = bus.Rd;
        end else if (bus.JMP && bus.flag_label_PC) begin
            pc_d = rel_base + label11_ext;
        end else if (bus.JMP && bus.flag_Rm_PC) begin
            pc_d = bus.Rm;
        end else if (bus.BRANCH) begin
            pc_d = rel_base + disp8_ext;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.Q = pc_q;

endmodule

// File: tb/tb_pc_circuit.sv
// ---------------------------------------------------------------------------
// tb_pc_circuit
// Self-checking bench for pc_circuit: directed cases followed by randomized
// select patterns, all checked against a behavioural next-PC model.
// ---------------------------------------------------------------------------
module tb_pc_circuit;

    logic clk;
    logic clr;
    int   total;
    int   bad;
    int   model_pc;

    pc_circuit_if bus ();

    pc_circuit #(.RESET_VECTOR(16'h0000)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: Q=%h", tag, got);
        end
    endtask

    // Reference next-PC from the rules, using plain integer arithmetic.
    function automatic int model_next();
        int base;
        int d8;
        int l11;
        int r;
`ifdef PC_REL_NEXT_EN
        base = model_pc + 1;
`else
        base = model_pc;
`endif
        d8  = $signed(bus.disp8);
        l11 = $signed(bus.label11);
        if (bus.JMP && bus.flag_Rd_PC)         r = int'(bus.Rd);
        else if (bus.JMP && bus.flag_label_PC) r = base + l11;
        else if (bus.JMP && bus.flag_Rm_PC)    r = int'(bus.Rm);
        else if (bus.BRANCH)                   r = base + d8;
        else                                   r = model_pc + 1;
        return r & 32'hFFFF;
    endfunction

    task automatic idle_inputs();
        bus.disp8 = 8'd0; bus.JMP = 1'b0; bus.BRANCH = 1'b0;
        bus.flag_Rd_PC = 1'b0; bus.flag_label_PC = 1'b0; bus.flag_Rm_PC = 1'b0;
        bus.label11 = 11'd0; bus.Rd = 16'd0; bus.Rm = 16'd0;
    endtask

    // One clock edge, model-checked.
    task automatic step(input string tag);
        int nxt;
        nxt = model_next();
        @(posedge clk);
        #1;
        model_pc = nxt;
        chk(tag, bus.Q, model_pc[15:0]);
    endtask

    // One clock edge, also checked against the hand-derived value for this build.
    task automatic step_exp(input string tag, input logic [15:0] exp_base_pc,
                            input logic [15:0] exp_base_next);
        logic [15:0] e;
`ifdef PC_REL_NEXT_EN
        e = exp_base_next;
`else
        e = exp_base_pc;
`endif
        step(tag);
        chk({tag, "_const"}, bus.Q, e);
    endtask

    task automatic jump_rd(input logic [15:0] v);
        idle_inputs();
        bus.JMP = 1'b1; bus.flag_Rd_PC = 1'b1; bus.Rd = v;
        step_exp("load_rd", v, v);
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_pc = 0;
        idle_inputs();
        clr = 1'b1;

        // Reset held for 5 clocks.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", bus.Q, 16'h0000);
        end
        clr = 1'b0;
        model_pc = 0;

        // Sequential from 0.
        step_exp("seq1", 16'd1, 16'd1);
        step_exp("seq2", 16'd2, 16'd2);
        step_exp("seq3", 16'd3, 16'd3);
        step_exp("seq4", 16'd4, 16'd4);
        jump_rd(16'hFFFF);
        step_exp("seq_wrap", 16'h0000, 16'h0000);

        // Asynchronous reset mid-cycle.
        jump_rd(16'd7);
        #3;
        clr = 1'b1;
        #1;
        chk("async_clr", bus.Q, 16'h0000);
        model_pc = 0;
        @(posedge clk);
        #1;
        chk("clr_edge", bus.Q, 16'h0000);
        clr = 1'b0;
        step_exp("after_clr", 16'd1, 16'd1);

        // Branches.
        jump_rd(16'd4);
        bus.BRANCH = 1'b1; bus.disp8 = 8'd5;
        step_exp("br_pos", 16'd9, 16'd10);
        bus.disp8 = 8'hFB;
        step_exp("br_neg", 16'd4, 16'd6);
        bus.JMP = 1'b1; bus.flag_Rd_PC = 1'b1; bus.Rd = 16'd20;
        step_exp("jmp_over_br", 16'd20, 16'd20);
        jump_rd(16'd2);
        bus.BRANCH = 1'b1; bus.disp8 = 8'hFB;
        step_exp("br_wrap", 16'hFFFD, 16'hFFFE);

        // Jump sources.
        jump_rd(16'd20);
        bus.JMP = 1'b1; bus.flag_label_PC = 1'b1; bus.label11 = 11'd15;
        step_exp("jmp_label", 16'd35, 16'd36);
        idle_inputs();
        bus.JMP = 1'b1; bus.flag_Rm_PC = 1'b1; bus.Rm = 16'd50;
        step_exp("jmp_rm", 16'd50, 16'd50);
        idle_inputs();
        bus.JMP = 1'b1; bus.flag_label_PC = 1'b1; bus.label11 = 11'h7FF;
        step_exp("jmp_label_neg", 16'd49, 16'd50);

        // Priority and ignored selects.
        idle_inputs();
        bus.JMP = 1'b1; bus.flag_Rd_PC = 1'b1; bus.flag_label_PC = 1'b1;
        bus.flag_Rm_PC = 1'b1; bus.Rd = 16'd3; bus.Rm = 16'd9; bus.label11 = 11'd100;
        step_exp("all_flags", 16'd3, 16'd3);
        jump_rd(16'd6);
        bus.flag_Rm_PC = 1'b1; bus.Rm = 16'd50;
        step_exp("flag_no_jmp", 16'd7, 16'd7);
        jump_rd(16'd6);
        bus.JMP = 1'b1;
        step_exp("jmp_no_flag", 16'd7, 16'd7);

        // Relative-base examples.
        jump_rd(16'd10);
        bus.BRANCH = 1'b1; bus.disp8 = 8'd5;
        step_exp("rel_br", 16'd15, 16'd16);
        jump_rd(16'd10);
        bus.JMP = 1'b1; bus.flag_label_PC = 1'b1; bus.label11 = 11'd15;
        step_exp("rel_label", 16'd25, 16'd26);

        // Input changes between edges leave Q alone.
        idle_inputs();
        bus.JMP = 1'b1; bus.flag_Rd_PC = 1'b1; bus.Rd = 16'h1234;
        #2;
        chk("no_midcycle", bus.Q, model_pc[15:0]);

        // Randomized selects.
        for (int i = 0; i < 300; i++) begin
            bus.disp8         = 8'($urandom);
            bus.label11       = 11'($urandom);
            bus.Rd            = 16'($urandom);
            bus.Rm            = 16'($urandom);
            bus.JMP           = 1'($urandom_range(0, 1));
            bus.BRANCH        = 1'($urandom_range(0, 1));
            bus.flag_Rd_PC    = ($urandom_range(0, 3) == 0);
            bus.flag_label_PC = ($urandom_range(0, 2) == 0);
            bus.flag_Rm_PC    = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_circuit.md
Name: pc_circuit

Overview:
Program-counter register and next-PC selection logic for the single-cycle 16-bit RISC core.
- Holds the current instruction address Q, which is word-addressed.
- Each clock it loads one of: the sequential address, a PC-relative conditional-branch target, a PC-relative unconditional-jump target, or an absolute register target (Rd or Rm).
- The decode/control unit drives BRANCH, JMP and the flag_* selects.
- Q feeds the instruction memory address.

Parameters:
- RESET_VECTOR, 16'h0000, value loaded into Q while clr is asserted.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- disp8  input  8  signed two's-complement conditional-branch displacement, in words.
- JMP  input  1  unconditional-jump enable; qualifies the flag_* selects.
- BRANCH  input  1  taken-conditional-branch enable; the condition is already evaluated by control.
- flag_Rd_PC  input  1  with JMP: target = Rd.
- flag_label_PC  input  1  with JMP: target = PC-relative label11.
- flag_Rm_PC  input  1  with JMP: target = Rm.
- label11  input  11  signed two's-complement jump displacement, in words.
- Rd  input  16  register value for absolute jump.
- Rm  input  16  register value for absolute jump.
- Q  output  16  current PC.

Behaviour:
- State: one 16-bit register PC, with Q = PC directly; no output logic after the register.
- Reset: clr high forces PC = RESET_VECTOR immediately, asynchronously, with no clock needed.
  - clr has priority over every other input.
  - Deasserting clr takes effect at the next rising clk edge, which loads next_pc normally.
- Update: on each rising clk edge with clr low, PC <= next_pc. Latency is one cycle from the select inputs to Q.
- BASE = PC (current Q) by default; see Optional Feature.
- next_pc priority, highest first:
  1. JMP=1 and flag_Rd_PC=1 -> Rd.
  2. JMP=1 and flag_label_PC=1 -> BASE + sign_extend16(label11).
  3. JMP=1 and flag_Rm_PC=1 -> Rm.
  4. BRANCH=1 -> BASE + sign_extend16(disp8).
  5. Otherwise -> PC + 1.
- JMP=1 with no flag set: falls through to the BRANCH/sequential rules.
- Multiple flags set: resolved strictly by the priority above, with no error indication.
- flag_* with JMP=0 are ignored.
- JMP has priority over BRANCH when both are high.
- Arithmetic: 16-bit modulo, with no overflow or carry output.
  - PC 16'hFFFF sequential -> 16'h0000.
  - Negative displacements below 0 wrap, e.g. PC=2, disp8=-5 -> 16'hFFFD.
- All next-PC logic is purely combinational. Inputs are sampled only at the clock edge; input changes between edges do not affect Q.

Optional Feature:
- Macro PC_REL_NEXT_EN.
- Defined: BASE = PC + 1, so relative targets are computed from the next-sequential address, e.g. PC=10, disp8=5 -> 16.
- Undefined (default): BASE = PC, e.g. PC=10, disp8=5 -> 15.
- Absolute jumps (Rd, Rm), sequential increment and reset are identical in both builds.

Test Plan:
- Reset: hold clr=1 for 5 clocks -> Q=0 throughout. Assert clr mid-cycle while Q=7 -> Q=0 immediately, before the next edge.
- Sequential: clr=0, all controls 0 for 4 edges from 0 -> Q=1,2,3,4. Force PC=16'hFFFF, one edge -> Q=0.
- Branch, macro undefined:
  - PC=4, BRANCH=1, disp8=5 -> Q=9.
  - Then disp8=8'hFB (-5) -> Q=4.
  - BRANCH=1 with JMP=1, flag_Rd_PC=1, Rd=20 -> Q=20, since JMP wins.
- Jump sources:
  - JMP=1, flag_Rd_PC=1, Rd=16'd20 -> Q=20.
  - Then flag_label_PC=1, label11=15 -> Q=35.
  - Then flag_Rm_PC=1, Rm=16'd50 -> Q=50.
  - label11=11'h7FF (-1) from PC=50 -> Q=49.
- Priority and ignore:
  - JMP=1 with all three flags set, Rd=3, Rm=9 -> Q=3.
  - JMP=0, flag_Rm_PC=1, Rm=50, PC=6 -> Q=7.
  - JMP=1 with no flag, PC=6 -> Q=7.
- PC_REL_NEXT_EN defined: PC=10, BRANCH=1, disp8=5 -> Q=16. PC=10, JMP=1, flag_label_PC=1, label11=15 -> Q=26.
